rf_port_arbiter: RTL
====================

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameter DATA_W, 8: register data width.
REQ-002 Parameter ADDR_W, 3: register index width (8 registers).
REQ-003 Parameter AGE_LIMIT, 4: starvation threshold, in cycles, for requester 2.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port req  input  3: requests; bit0 core RF read, bit1 core writeback, bit2 display scan.
REQ-007 Port addr0/addr1/addr2  input  ADDR_W each: register index per requester.
REQ-008 Port wdata1  input  DATA_W: writeback data (requester 1 only writes).
REQ-009 Port gnt  output  3: one-hot or zero grant, registered.
REQ-010 Port rf_addr  output  ADDR_W: muxed index of the granted requester; 0 when idle.
REQ-011 Port rf_we  output  1: high only while requester 1 holds the grant.
REQ-012 Port rf_wdata  output  DATA_W: wdata1 when rf_we is high, else 0.
REQ-013 Port busy  output  1: high while any grant is active.

Function
REQ-014 The FSM shall have two states: IDLE (no grant) and OWNED (exactly one gnt bit high).
REQ-015 IDLE->OWNED: if req is nonzero at edge N, gnt shall be high from edge N+1 (1-cycle latency).
REQ-016 Base priority shall be fixed: writeback (1) > read (0) > display (2).
REQ-017 In OWNED, the grant shall hold while the owner's req stays high (lock), without preemption.
REQ-018 When the owner drops req at edge N and another req is high, the new grant shall appear at N+1, with no idle cycle.
REQ-019 When the owner drops req and no other req is high, the FSM shall return to IDLE at N+1.
REQ-020 gnt bits shall never be high for a requester whose req is low, except the single cycle after release.
REQ-021 rf_addr, rf_we and rf_wdata shall be combinational from gnt and the owner's inputs.
REQ-022 Simultaneous requests in IDLE shall be resolved purely by priority (REQ-016, REQ-026).
REQ-023 busy shall equal |gnt.

Reset
REQ-024 rst_n low shall force gnt=0, busy=0, rf_we=0, rf_addr=0, state=IDLE and age counter=0 immediately, without waiting for clk.
REQ-025 Reset asserted mid-grant shall drop the grant at once; after release, the first grant shall follow REQ-015.

Configuration
REQ-026 With ARB_AGING_EN defined: a saturating counter shall count cycles with req[2] high and gnt[2] low; at count=AGE_LIMIT, requester 2 shall take top priority at the next arbitration point. The counter shall clear when gnt[2] rises.
REQ-027 Without ARB_AGING_EN: no counter logic, strict REQ-016 priority; requester 2 may starve.

Structure
REQ-028 Package rf_arb_pkg shall hold requester ID constants (REQ_RD=0, REQ_WB=1, REQ_DISP=2) and the FSM state encoding.
REQ-029 Aging logic shall be a sub-module rf_arb_age_ctr, instantiated only under ARB_AGING_EN.

Verification
REQ-030 Reset: rst_n low mid-grant with gnt=010 -> gnt=000 and busy=0 before the next clk edge.
REQ-031 Latency: req=001 at edge 5 -> gnt=001 at edge 6; rf_addr=addr0, rf_we=0.
REQ-032 Priority and lock: req=011 in IDLE -> gnt=010, rf_we=1, rf_wdata=wdata1; req0 still high when req1 drops at edge N -> gnt=001 at N+1.
REQ-033 Release to idle: sole owner drops req at edge N -> gnt=000 and busy=0 at N+1.
REQ-034 Aging (ARB_AGING_EN, AGE_LIMIT=4): req2 held while req0/req1 alternate with back-to-back grants -> gnt=100 at the first arbitration point after 4 waiting cycles; without the macro -> gnt[2] stays 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Purpose : Shared definitions for the register-file port arbiter.
//           - Requester IDs (bit positions in req/gnt).
//           - FSM state encoding.
//           - Priority pick function.
// Ports   : none (package)
// Config  : ARB_AGING_EN (used by rf_port_arbiter) lets a starving display
//           requester jump to the top of the priority order.
// ---------------------------------------------------------------------------
package rf_arb_pkg;

   localparam int unsigned NUM_REQ  = 3;
   localparam int unsigned REQ_RD   = 0;  // core RF read
   localparam int unsigned REQ_WB   = 1;  // core writeback
   localparam int unsigned REQ_DISP = 2;  // display scan

   typedef enum logic {
      StIdle  = 1'b0,
      StOwned = 1'b1
   } arb_state_e;

   // Fixed order WB > RD > DISP; an aged display request overrides it.
   function automatic logic [NUM_REQ-1:0] arb_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic               age_hit);
      logic [NUM_REQ-1:0] gnt;
      gnt = '0;
      if (age_hit && req[REQ_DISP]) begin
         gnt[REQ_DISP] = 1'b1;
      end else if (req[REQ_WB]) begin
         gnt[REQ_WB] = 1'b1;
      end else if (req[REQ_RD]) begin
         gnt[REQ_RD] = 1'b1;
      end else if (req[REQ_DISP]) begin
         gnt[REQ_DISP] = 1'b1;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/rf_arb_age_ctr.sv
// ---------------------------------------------------------------------------
// rf_arb_age_ctr
// Purpose : Saturating wait counter for the display requester. Counts cycles
//           in which the display requests but is not granted; raises
//           o_age_hit once the count reaches AGE_LIMIT. Cleared while the
//           display holds the grant.
// Ports   : clk        - clock
//           rst_n      - asynchronous active-low reset
//           i_wait     - display requesting and not granted this cycle
//           i_gnt_disp - display currently holds the grant
//           o_age_hit  - count has reached AGE_LIMIT
// Config  : only instantiated when ARB_AGING_EN is defined.
// ---------------------------------------------------------------------------
module rf_arb_age_ctr #(
   parameter int unsigned AGE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_wait,
   input  logic i_gnt_disp,
   output logic o_age_hit
);

   localparam int unsigned         CNT_W = $clog2(AGE_LIMIT + 1);
   localparam logic [CNT_W-1:0]    LIMIT = CNT_W'(AGE_LIMIT);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_gnt_disp) begin
         r_cnt <= '0;
      end else if (i_wait && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_age_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/rf_port_arbiter.sv
// ---------------------------------------------------------------------------
// rf_port_arbiter
// Purpose : Arbitrates one register-file port between three requesters
//           (core read, core writeback, display scan). Grants are registered,
//           locked while the owner keeps requesting, and handed over without
//           an idle cycle when the owner releases.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           req[2:0]            - requests (0 read, 1 writeback, 2 display)
//           addr0/addr1/addr2   - register index per requester
//           wdata1              - writeback data
//           gnt[2:0]            - registered one-hot (or zero) grant
//           rf_addr             - index of the granted requester, 0 when idle
//           rf_we               - write enable, high while writeback owns
//           rf_wdata            - wdata1 while rf_we, else 0
//           busy                - any grant active
// Config  : ARB_AGING_EN - when defined, a display request waiting AGE_LIMIT
//           cycles takes top priority at the next arbitration point.
// ---------------------------------------------------------------------------
module rf_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned AGE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata1,
   output logic [2:0]        gnt,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_we,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy
);

   if (AGE_LIMIT < 1) begin : g_bad_age_limit
      $error("AGE_LIMIT must be at least 1");
   end

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [2:0]       r_gnt;
   logic [2:0]       w_gnt_nxt;
   logic [2:0]       w_pick;
   logic             w_age_hit;

`ifdef ARB_AGING_EN
   logic w_disp_wait;
   assign w_disp_wait = req[REQ_DISP] & ~r_gnt[REQ_DISP];

   rf_arb_age_ctr #(
      .AGE_LIMIT (AGE_LIMIT)
   ) u_age_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wait     (w_disp_wait),
      .i_gnt_disp (r_gnt[REQ_DISP]),
      .o_age_hit  (w_age_hit)
   );
`else
   assign w_age_hit = 1'b0;
`endif

   assign w_pick = arb_pick(req, w_age_hit);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      case (r_state)
         StIdle: begin
            if (|req) begin
               w_state_nxt = StOwned;
               w_gnt_nxt   = w_pick;
            end
         end
         StOwned: begin
            // Owner's req low: hand over directly (owner bit is already 0 in req).
            if (!(|(req & r_gnt))) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = (|req) ? StOwned : StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // Output logic: port mux follows the registered grant
   always_comb begin
      rf_addr = '0;
      unique case (r_gnt)
         3'b001:  rf_addr = addr0;
         3'b010:  rf_addr = addr1;
         3'b100:  rf_addr = addr2;
         default: rf_addr = '0;
      endcase
      gnt      = r_gnt;
      rf_we    = r_gnt[REQ_WB];
      rf_wdata = rf_we ? wdata1 : '0;
      busy     = |r_gnt;
   end

endmodule
